sram_port_arbiter: RTL and testbench

- Shares the single-port byte-addressable 64 KiB SRAM between two requesters:
  - port I: instruction fetch, read-only, word-sized.
  - port D: data load/store, byte/half/3-byte/word sizes.
- Arbitrates and registers the SRAM command.
- Returns read data with one response pulse per granted request, and sign/zero-extends D loads.
- Sits between the core's fetch/LSU and the SRAM (SRAM: clk, wen[3:0], addr[15:0], wdata[31:0], combinational rdata[31:0]).

---
 rtl/sram_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of a single-port byte-addressable SRAM: instruction fetch (I)
// and data load/store (D) share one registered SRAM command, and each granted request gets one response pulse.
module sram_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [3:0]        sram_wen,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            last_owner_q, last_owner_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [3:0]        sram_wen_q, sram_wen_d;
    logic [31:0]       sram_wdata_q, sram_wdata_d;
    logic              i_rvalid_q, i_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [31:0]       i_rdata_q, i_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic              grant_ok;
    logic              pick_d;
    logic [31:0]       load_ext;

    function automatic logic [3:0] size_to_wen(input logic [1:0] size);
        case (size)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            2'b11:   return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    // Grants only when the SRAM command register is free; RESP overlaps the next grant.
    assign grant_ok = ~rst & ((state_q == IDLE) | (state_q == RESP));

    always_comb begin
        pick_d = 1'b0;
        if (d_req && !i_req) begin
            pick_d = 1'b1;
        end else if (d_req && i_req) begin
            pick_d = RR_EN ? (last_owner_q == OWN_I) : 1'b1;
        end
    end

    assign d_gnt = grant_ok & d_req & pick_d;
    assign i_gnt = grant_ok & i_req & ~pick_d;

    always_comb begin
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & sram_rdata[7]}},  sram_rdata[7:0]};
            2'b01:   load_ext = {{16{~uns_q & sram_rdata[15]}}, sram_rdata[15:0]};
            2'b11:   load_ext = {{8{~uns_q & sram_rdata[23]}},  sram_rdata[23:0]};
            default: load_ext = sram_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        sram_addr_d  = sram_addr_q;
        sram_wen_d   = sram_wen_q;
        sram_wdata_d = sram_wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_rvalid_d   = 1'b0;
        d_rvalid_d   = 1'b0;

        case (state_q)
            ACCESS: begin
                if (owner_q == OWN_D) begin
                    d_rdata_d  = we_q ? 32'd0 : load_ext;
                    d_rvalid_d = 1'b1;
                end else begin
                    i_rdata_d  = sram_rdata;
                    i_rvalid_d = 1'b1;
                end
                sram_wen_d = 4'b0000;
                state_d    = RESP;
            end
            default: state_d = IDLE;
        endcase

        // A grant in IDLE or RESP overrides the fall-back to IDLE.
        if (i_gnt || d_gnt) begin
            owner_d      = d_gnt ? OWN_D : OWN_I;
            last_owner_d = d_gnt ? OWN_D : OWN_I;
            we_d         = d_gnt & d_we;
            size_d       = d_size;
            uns_d        = d_unsigned;
            sram_addr_d  = d_gnt ? d_addr : i_addr;
            sram_wdata_d = d_gnt ? d_wdata : 32'd0;
            sram_wen_d   = (d_gnt && d_we) ? size_to_wen(d_size) : 4'b0000;
            state_d      = ACCESS;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_I;
            last_owner_q <= OWN_D;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            sram_addr_q  <= '0;
            sram_wen_q   <= 4'b0000;
            sram_wdata_q <= 32'd0;
            i_rvalid_q   <= 1'b0;
            d_rvalid_q   <= 1'b0;
            i_rdata_q    <= 32'd0;
            d_rdata_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            sram_addr_q  <= sram_addr_d;
            sram_wen_q   <= sram_wen_d;
            sram_wdata_q <= sram_wdata_d;
            i_rvalid_q   <= i_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign sram_addr  = sram_addr_q;
    assign sram_wen   = sram_wen_q;
    assign sram_wdata = sram_wdata_q;
    assign i_rvalid   = i_rvalid_q;
    assign d_rvalid   = d_rvalid_q;
    assign i_rdata    = i_rdata_q;
    assign d_rdata    = d_rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: a round-robin instance on a behavioural SRAM with a scoreboard,
// plus a fixed-priority instance for the starvation scenario.
`timescale 1ns/1ps
module tb_sram_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        i_req = 1'b0;
    logic [15:0] i_addr = 16'd0;
    logic        i_gnt, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0, d_we = 1'b0, d_unsigned = 1'b0;
    logic [1:0]  d_size = 2'b00;
    logic [15:0] d_addr = 16'd0;
    logic [31:0] d_wdata = 32'd0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic [15:0] sram_addr;
    logic [3:0]  sram_wen;
    logic [31:0] sram_wdata, sram_rdata;

    logic        fp_i_req = 1'b0, fp_d_req = 1'b0;
    logic [15:0] fp_i_addr = 16'h0008, fp_d_addr = 16'h0044;
    logic [31:0] fp_d_wdata = 32'd0, fp_sram_rdata = 32'd0;
    logic        fp_i_gnt, fp_i_rvalid, fp_d_gnt, fp_d_rvalid;
    logic [31:0] fp_i_rdata, fp_d_rdata, fp_sram_wdata;
    logic [15:0] fp_sram_addr;
    logic [3:0]  fp_sram_wen;

    sram_port_arbiter #(.ADDR_W(16), .RR_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .sram_addr(sram_addr), .sram_wen(sram_wen), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    sram_port_arbiter #(.ADDR_W(16), .RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst(rst),
        .i_req(fp_i_req), .i_addr(fp_i_addr), .i_gnt(fp_i_gnt), .i_rvalid(fp_i_rvalid), .i_rdata(fp_i_rdata),
        .d_req(fp_d_req), .d_we(1'b0), .d_size(2'b10), .d_unsigned(1'b0), .d_addr(fp_d_addr),
        .d_wdata(fp_d_wdata), .d_gnt(fp_d_gnt), .d_rvalid(fp_d_rvalid), .d_rdata(fp_d_rdata),
        .sram_addr(fp_sram_addr), .sram_wen(fp_sram_wen), .sram_wdata(fp_sram_wdata), .sram_rdata(fp_sram_rdata)
    );

    typedef struct packed {
        logic        is_d;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [15:0] addr;
        logic [31:0] wdata;
    } op_t;

    typedef struct packed {
        logic [31:0] data;
        int          due;
    } rsp_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    rsp_t iq[$];
    rsp_t dq[$];
    logic order_q[$];
    int   gcyc_q[$];
    logic rec_en = 1'b0;
    op_t  pend;
    logic pend_v = 1'b0;
    int   busy = 0;
    logic last_was_d = 1'b1;

    logic [7:0] mem [0:65535];
    logic [7:0] ref_mem [0:65535];
    logic       mem_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_byte(input int a);
        return 8'((a * 37 + 11) % 256);
    endfunction

    function automatic logic [31:0] init_word(input int a);
        return {init_byte((a + 3) % 65536), init_byte((a + 2) % 65536),
                init_byte((a + 1) % 65536), init_byte(a % 65536)};
    endfunction

    // Behavioural SRAM: per-byte writes at the clock edge, combinational read with 16-bit wrap.
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int a = 0; a < 65536; a++) mem[a] <= init_byte(a);
            mem_ready <= 1'b1;
        end else begin
            for (int k = 0; k < 4; k++)
                if (sram_wen[k]) mem[16'(sram_addr + 16'(k))] <= sram_wdata[8*k +: 8];
        end
    end
    assign sram_rdata = {mem[sram_addr + 16'd3], mem[sram_addr + 16'd2], mem[sram_addr + 16'd1], mem[sram_addr]};

    function automatic void check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic int nbytes(input logic [1:0] size);
        case (size)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 3;
        endcase
    endfunction

    function automatic logic [3:0] wen_of(input logic [1:0] size);
        return 4'((1 << nbytes(size)) - 1);
    endfunction

    function automatic void commit(input op_t op);
        int          n;
        logic [31:0] w;
        rsp_t        r;
        n = op.is_d ? nbytes(op.size) : 4;
        w = 32'd0;
        if (op.is_d && op.we) begin
            for (int k = 0; k < n; k++) ref_mem[16'(op.addr + 16'(k))] = op.wdata[8*k +: 8];
        end else begin
            for (int k = 0; k < n; k++) w[8*k +: 8] = ref_mem[16'(op.addr + 16'(k))];
            if (op.is_d && !op.uns && n < 4 && w[8*n-1]) w = w | (32'hFFFF_FFFF << (8*n));
        end
        r.data = w;
        r.due  = cyc + 1;
        if (op.is_d) dq.push_back(r);
        else iq.push_back(r);
    endfunction

    // Reference model: a grant may be issued when no access is outstanding; the access completes one cycle later.
    always @(negedge clk) begin
        logic       can, exp_i, exp_d;
        logic [3:0] exp_wen;
        if (rst) begin
            pend_v     = 1'b0;
            busy       = 0;
            last_was_d = 1'b1;
            check_output("gnt_in_reset", 32'({i_gnt, d_gnt}), 32'd0);
            check_output("wen_in_reset", 32'(sram_wen), 32'd0);
        end else begin
            exp_wen = (pend_v && pend.is_d && pend.we) ? wen_of(pend.size) : 4'd0;
            check_output("sram_wen", 32'(sram_wen), 32'(exp_wen));
            if (pend_v) begin
                check_output("sram_addr", 32'(sram_addr), 32'(pend.addr));
                if (pend.is_d && pend.we) check_output("sram_wdata", sram_wdata, pend.wdata);
                commit(pend);
                pend_v = 1'b0;
            end
            can = (busy == 0);
            if (busy > 0) busy--;
            exp_i = can && i_req && (!d_req || last_was_d);
            exp_d = can && d_req && !exp_i;
            check_output("grant", 32'({i_gnt, d_gnt}), 32'({exp_i, exp_d}));
            if (exp_i || exp_d) begin
                pend = '{is_d: exp_d, we: exp_d && d_we, size: d_size, uns: d_unsigned,
                         addr: exp_d ? d_addr : i_addr, wdata: d_wdata};
                pend_v     = 1'b1;
                busy       = 1;
                last_was_d = exp_d;
                if (rec_en) begin
                    order_q.push_back(exp_d);
                    gcyc_q.push_back(cyc);
                end
            end
        end
    end

    // Monitor: every response pulse must match the oldest expected response of its port, on time.
    always @(negedge clk) begin
        rsp_t r;
        if (i_rvalid) begin
            if (iq.size() == 0) check_output("i_rvalid_unexpected", 32'd1, 32'd0);
            else begin
                r = iq.pop_front();
                check_output("i_rdata", i_rdata, r.data);
                check_output("i_rvalid_cycle", 32'(cyc), 32'(r.due));
            end
        end else if (iq.size() > 0 && iq[0].due <= cyc) begin
            check_output("i_rvalid_missing", 32'd0, 32'd1);
            void'(iq.pop_front());
        end
        if (d_rvalid) begin
            if (dq.size() == 0) check_output("d_rvalid_unexpected", 32'd1, 32'd0);
            else begin
                r = dq.pop_front();
                check_output("d_rdata", d_rdata, r.data);
                check_output("d_rvalid_cycle", 32'(cyc), 32'(r.due));
            end
        end else if (dq.size() > 0 && dq[0].due <= cyc) begin
            check_output("d_rvalid_missing", 32'd0, 32'd1);
            void'(dq.pop_front());
        end
    end

    task automatic d_issue(input logic we, input logic [1:0] size, input logic uns,
                           input logic [15:0] addr, input logic [31:0] wdata);
        logic got;
        d_req = 1'b1; d_we = we; d_size = size; d_unsigned = uns; d_addr = addr; d_wdata = wdata;
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            got = d_gnt;
        end
        if (!got) check_output("d_gnt_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    task automatic i_issue(input logic [15:0] addr);
        logic got;
        i_req = 1'b1; i_addr = addr;
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            got = i_gnt;
        end
        if (!got) check_output("i_gnt_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        i_req = 1'b0;
    endtask

    task automatic d_store(input logic [1:0] size, input logic [15:0] addr, input logic [31:0] wdata,
                           input logic [3:0] exp_wen, input string name);
        d_issue(1'b1, size, 1'b0, addr, wdata);
        @(negedge clk);
        check_output({name, "_wen"}, 32'(sram_wen), 32'(exp_wen));
        @(negedge clk);
        check_output({name, "_rvalid"}, 32'(d_rvalid), 32'd1);
        check_output({name, "_rdata"}, d_rdata, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic d_load(input logic [1:0] size, input logic uns, input logic [15:0] addr,
                          input logic [31:0] exp, input string name);
        d_issue(1'b0, size, uns, addr, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check_output({name, "_rvalid"}, 32'(d_rvalid), 32'd1);
        check_output(name, d_rdata, exp);
        @(posedge clk); #1;
    endtask

    task automatic i_fetch(input logic [15:0] addr, input logic [31:0] exp, input string name);
        i_issue(addr);
        @(negedge clk);
        @(negedge clk);
        check_output({name, "_rvalid"}, 32'(i_rvalid), 32'd1);
        check_output(name, i_rdata, exp);
        @(posedge clk); #1;
    endtask

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 16'(32'hFFF0 + $urandom_range(0, 15));
        return 16'($urandom_range(0, 63));
    endfunction

    task automatic apply_stimulus(input logic port_d, input int n);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            if (port_d)
                d_issue($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                        rand_addr(), $urandom());
            else
                i_issue(rand_addr());
        end
    endtask

    task automatic reset_dut();
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
    endtask

    initial begin
        int fp_d_cnt, fp_rv_cnt;
        logic got;
        for (int a = 0; a < 65536; a++) ref_mem[a] = init_byte(a);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_i_rdata", i_rdata, 32'd0);
        check_output("reset_d_rdata", d_rdata, 32'd0);
        check_output("reset_sram_addr", 32'(sram_addr), 32'd0);
        check_output("reset_sram_wdata", sram_wdata, 32'd0);
        check_output("reset_rvalid", 32'({i_rvalid, d_rvalid}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        d_store(2'b10, 16'h0010, 32'hDEADBEEF, 4'b1111, "st_word");
        i_fetch(16'h0010, 32'hDEADBEEF, "fetch_after_store");

        d_store(2'b00, 16'h0020, 32'h0000_0080, 4'b0001, "st_byte");
        d_load(2'b00, 1'b0, 16'h0020, 32'hFFFF_FF80, "ld_byte_signed");
        d_load(2'b00, 1'b1, 16'h0020, 32'h0000_0080, "ld_byte_unsigned");
        d_store(2'b01, 16'h0024, 32'h0000_8001, 4'b0011, "st_half");
        d_load(2'b01, 1'b0, 16'h0024, 32'hFFFF_8001, "ld_half_signed");

        d_store(2'b11, 16'h0030, 32'hAA123456, 4'b0111, "st_3byte");
        d_load(2'b10, 1'b0, 16'h0030, {init_byte(16'h0033), 24'h123456}, "ld_after_3byte");

        d_store(2'b10, 16'hFFFE, 32'h11223344, 4'b1111, "st_wrap");
        d_load(2'b10, 1'b0, 16'hFFFE, 32'h11223344, "ld_wrap_word");
        d_load(2'b00, 1'b1, 16'h0000, 32'h0000_0022, "ld_wrap_byte0");
        i_fetch(16'hFFFE, 32'h11223344, "fetch_wrap");

        // Reset lands in the ACCESS cycle of a store: the write and its response must vanish.
        d_issue(1'b1, 2'b10, 1'b0, 16'h0040, 32'hCAFEF00D);
        #1 rst = 1'b1;
        #1 check_output("wen_cleared_by_rst", 32'(sram_wen), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_output("no_d_rvalid_after_rst", 32'(d_rvalid), 32'd0);
        end
        @(posedge clk); #1;
        d_load(2'b10, 1'b0, 16'h0040, init_word(16'h0040), "mem_unchanged_after_rst");

        reset_dut();
        order_q.delete();
        gcyc_q.delete();
        rec_en = 1'b1;
        fork
            for (int k = 0; k < 6; k++) i_issue(16'(4 * k));
            for (int k = 0; k < 6; k++) d_issue(1'b0, 2'b10, 1'b0, 16'h0010, 32'd0);
        join
        rec_en = 1'b0;
        check_output("rr_grant_count", 32'(order_q.size()), 32'd12);
        for (int k = 0; k < order_q.size() && k < 12; k++) begin
            check_output("rr_order", 32'(order_q[k]), 32'(k % 2));
            if (k > 0) check_output("rr_cadence", 32'(gcyc_q[k] - gcyc_q[k-1]), 32'd2);
        end

        fp_d_req = 1'b1;
        fp_i_req = 1'b1;
        fp_d_cnt = 0;
        fp_rv_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check_output("fp_i_starved", 32'(fp_i_gnt), 32'd0);
            check_output("fp_i_no_rvalid", 32'(fp_i_rvalid), 32'd0);
            if (fp_d_gnt) fp_d_cnt++;
            if (fp_d_rvalid) fp_rv_cnt++;
        end
        check_output("fp_d_grant_count", 32'(fp_d_cnt), 32'd10);
        check_output("fp_d_rvalid_count", 32'(fp_rv_cnt), 32'd9);
        @(posedge clk); #1;
        fp_d_req = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 4 && !got; n++) begin
            @(negedge clk);
            got = fp_i_gnt;
        end
        check_output("fp_i_granted_after_d_drops", 32'(got), 32'd1);
        @(posedge clk); #1;
        fp_i_req = 1'b0;
        @(negedge clk);
        check_output("fp_sram_addr", 32'(fp_sram_addr), 32'h0008);
        check_output("fp_sram_cmd", {fp_sram_wdata[27:0], fp_sram_wen}, 32'd0);
        @(negedge clk);
        check_output("fp_rdata", fp_i_rdata | fp_d_rdata, 32'd0);

        @(posedge clk); #1;
        fork
            apply_stimulus(1'b0, 40);
            apply_stimulus(1'b1, 40);
        join

        repeat (6) begin @(posedge clk); #1; end
        check_output("i_queue_drained", 32'(iq.size()), 32'd0);
        check_output("d_queue_drained", 32'(dq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
